yin_threshold_module: RTL and testbench

//  YIN absolute-threshold / period-pick stage. Sits directly downstream of the cumulative-mean-normalised

---
 rtl/yin_threshold_module.sv | 188 ++++++++++++++++++
 tb/tb_yin_threshold_module.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yin_threshold_module.sv
// YIN absolute-threshold / period-pick stage: scans a snapshot of the CMNDF bus for the first
// sub-threshold tau, follows the dip to its local minimum, else falls back to the global minimum.
module yin_threshold_module #(
  parameter int unsigned INTERMEDIATE_DATA_WIDTH = 64,
  parameter int unsigned MAX_TAU                 = 40,
  parameter int unsigned MIN_TAU                 = 2,
  parameter int unsigned TAU_BITS                = 6
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        results_valid,
  input  logic [MAX_TAU*INTERMEDIATE_DATA_WIDTH-1:0]  results,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0]          threshold,
  output logic                                        busy,
  output logic                                        done,
  output logic [TAU_BITS-1:0]                         tau_est,
  output logic [INTERMEDIATE_DATA_WIDTH-1:0]          tau_value,
  output logic                                        voiced
);

  localparam int unsigned W = INTERMEDIATE_DATA_WIDTH;
  localparam logic [TAU_BITS-1:0] FirstTau = TAU_BITS'(MIN_TAU);
  localparam logic [TAU_BITS-1:0] LastTau  = TAU_BITS'(MAX_TAU - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDescend
  } state_e;

  state_e               state_q, state_d;
  logic                 valid_q;
  logic                 start;

  logic [W-1:0]         words_q [MAX_TAU];
  logic [W-1:0]         thr_q;

  logic [TAU_BITS-1:0]  idx_q, idx_d;
  logic [TAU_BITS-1:0]  cand_q, cand_d;
  logic [TAU_BITS-1:0]  min_idx_q, min_idx_d;
  logic [W-1:0]         min_val_q, min_val_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [TAU_BITS-1:0]  tau_est_q, tau_est_d;
  logic [W-1:0]         tau_value_q, tau_value_d;
  logic                 voiced_q, voiced_d;

  logic [W-1:0]         cur_word;
  logic [W-1:0]         cand_word;
  logic                 at_last;

  assign cur_word  = words_q[idx_q];
  assign cand_word = words_q[cand_q];
  assign at_last   = (idx_q == LastTau);

  // Only a low-to-high transition seen while idle opens a frame.
  assign start = results_valid & ~valid_q & (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cand_d      = cand_q;
    min_idx_d   = min_idx_q;
    min_val_d   = min_val_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tau_est_d   = tau_est_q;
    tau_value_d = tau_value_q;
    voiced_d    = voiced_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StScan;
          idx_d     = FirstTau;
          busy_d    = 1'b1;
          // All-ones seed: any real word that is smaller replaces it, an all-ones frame keeps it.
          min_idx_d = FirstTau;
          min_val_d = '1;
        end
      end

      StScan: begin
        if (cur_word < min_val_q) begin
          min_idx_d = idx_q;
          min_val_d = cur_word;
        end
        if (cur_word < thr_q) begin
          cand_d = idx_q;
          if (at_last) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            tau_est_d   = idx_q;
            tau_value_d = cur_word;
            voiced_d    = 1'b1;
          end else begin
            state_d = StDescend;
            idx_d   = idx_q + 1'b1;
          end
        end else if (at_last) begin
          state_d     = StIdle;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          tau_est_d   = min_idx_d;
          tau_value_d = min_val_d;
          voiced_d    = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StDescend: begin
        if (cur_word < cand_word) begin
          cand_d = idx_q;
          if (at_last) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            tau_est_d   = idx_q;
            tau_value_d = cur_word;
            voiced_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d     = StIdle;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          tau_est_d   = cand_q;
          tau_value_d = cand_word;
          voiced_d    = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      cand_q      <= '0;
      min_idx_q   <= '0;
      min_val_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tau_est_q   <= '0;
      tau_value_q <= '0;
      voiced_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= results_valid;
      idx_q       <= idx_d;
      cand_q      <= cand_d;
      min_idx_q   <= min_idx_d;
      min_val_q   <= min_val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tau_est_q   <= tau_est_d;
      tau_value_q <= tau_value_d;
      voiced_q    <= voiced_d;
    end
  end

  // Frame snapshot; contents only matter while busy, so no reset is needed.
  always_ff @(posedge clk) begin
    if (start) begin
      thr_q <= threshold;
      for (int t = 0; t < MAX_TAU; t++) begin
        words_q[t] <= results[t*W +: W];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tau_est   = tau_est_q;
  assign tau_value = tau_value_q;
  assign voiced    = voiced_q;

endmodule

// File: tb/tb_yin_threshold_module.sv
// Self-checking bench for yin_threshold_module: directed frames plus randomized frames
// compared against a plain-loop reference of the period-pick rules.
module tb_yin_threshold_module;

  localparam int W    = 64;
  localparam int MAXT = 40;
  localparam int MINT = 2;
  localparam int TB   = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                results_valid;
  logic [MAXT*W-1:0]   results;
  logic [W-1:0]        threshold;
  logic                busy;
  logic                done;
  logic [TB-1:0]       tau_est;
  logic [W-1:0]        tau_value;
  logic                voiced;

  logic [W-1:0]        dat [MAXT];
  logic [W-1:0]        thr;

  int checks = 0;
  int errors = 0;

  yin_threshold_module #(
    .INTERMEDIATE_DATA_WIDTH (W),
    .MAX_TAU                 (MAXT),
    .MIN_TAU                 (MINT),
    .TAU_BITS                (TB)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .results_valid (results_valid),
    .results       (results),
    .threshold     (threshold),
    .busy          (busy),
    .done          (done),
    .tau_est       (tau_est),
    .tau_value     (tau_value),
    .voiced        (voiced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: first sub-threshold tau, walk downhill; else lowest-index global minimum.
  task automatic model(output int e_tau, output logic [W-1:0] e_val, output bit e_voiced,
                       output int e_edge);
    int last;
    int mi;
    mi = MINT;
    for (int t = MINT; t < MAXT; t++) if (dat[t] < dat[mi]) mi = t;
    e_tau    = mi;
    e_val    = dat[mi];
    e_voiced = 1'b0;
    last     = MAXT - 1;
    for (int t = MINT; t < MAXT; t++) begin
      if (dat[t] < thr) begin
        int c;
        c = t;
        while (c + 1 < MAXT && dat[c+1] < dat[c]) c++;
        e_tau    = c;
        e_val    = dat[c];
        e_voiced = 1'b1;
        last     = (c + 1 < MAXT) ? c + 1 : c;
        break;
      end
    end
    e_edge = last - MINT + 2;
  endtask

  task automatic fill_default();
    for (int t = 0; t < MAXT; t++) dat[t] = 64'd1000;
    thr = 64'd400;
  endtask

  task automatic drive_bus();
    for (int t = 0; t < MAXT; t++) results[t*W +: W] = dat[t];
    threshold = thr;
  endtask

  // Starts a frame from dat/thr and checks timing and result; corrupt_at > 0 scrambles
  // the inputs after that edge to show the frame works from its snapshot.
  task automatic run_frame(input string tag, input int corrupt_at, input bit drop_valid);
    int          e_tau;
    logic [W-1:0] e_val;
    bit          e_voiced;
    int          e_edge;
    int          n;
    bit          seen;
    model(e_tau, e_val, e_voiced, e_edge);
    @(negedge clk);
    drive_bus();
    results_valid = 1'b1;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (i == 1) check({tag, "_busy_hi"}, {63'd0, busy}, 64'd1);
      if (i == corrupt_at) begin
        results   = '0;
        threshold = '1;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_edge"}, 64'(n), 64'(e_edge));
      check({tag, "_tau"}, {58'd0, tau_est}, 64'(e_tau));
      check({tag, "_value"}, tau_value, e_val);
      check({tag, "_voiced"}, {63'd0, voiced}, {63'd0, e_voiced});
      check({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
      check({tag, "_hold_tau"}, {58'd0, tau_est}, 64'(e_tau));
    end
    if (drop_valid) begin
      results_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int dones;
    reset         = 1'b0;
    results_valid = 1'b0;
    results       = '0;
    threshold     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_voiced", {63'd0, voiced}, 64'd0);
    check("rst_tau", {58'd0, tau_est}, 64'd0);
    check("rst_value", tau_value, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);

    // Dip followed to local minimum.
    fill_default();
    dat[10] = 300; dat[11] = 200; dat[12] = 250;
    run_frame("t1", 0, 1'b1);

    // No crossing: lowest-index global minimum.
    fill_default();
    dat[20] = 500; dat[30] = 500;
    run_frame("t2", 0, 1'b1);

    // Crossing at last index.
    fill_default();
    dat[39] = 100;
    run_frame("t3", 0, 1'b1);

    // Indices below MIN_TAU ignored, equal neighbour not taken.
    fill_default();
    dat[0] = 0; dat[1] = 0; dat[5] = 300; dat[6] = 300; dat[7] = 350;
    run_frame("t4", 0, 1'b1);

    // Reset mid-frame aborts.
    fill_default();
    dat[20] = 500; dat[30] = 500;
    @(negedge clk);
    drive_bus();
    results_valid = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    reset         = 1'b0;
    results_valid = 1'b0;
    #1;
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_done", {63'd0, done}, 64'd0);
    check("t5_tau", {58'd0, tau_est}, 64'd0);
    check("t5_value", tau_value, 64'd0);
    check("t5_voiced", {63'd0, voiced}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("t5_no_done", 64'(dones), 64'd0);
    fill_default();
    dat[10] = 300; dat[11] = 200; dat[12] = 250;
    run_frame("t5_t1", 0, 1'b1);

    // Valid held high: no retrigger.
    run_frame("t6_t1", 0, 1'b0);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("t6_hold_dones", 64'(dones), 64'd0);
    results_valid = 1'b0;
    @(posedge clk);
    #1;

    // Inputs scrambled mid-scan.
    fill_default();
    dat[20] = 500; dat[30] = 500;
    run_frame("t6_snap", 5, 1'b1);

    // Randomized frames; narrow ranges force ties and long descents.
    for (int f = 0; f < 40; f++) begin
      int hi;
      hi = (f % 3 == 0) ? 7 : ((f % 3 == 1) ? 200 : 100000);
      for (int t = 0; t < MAXT; t++) dat[t] = 64'($urandom_range(0, hi));
      if (f % 5 == 0) dat[$urandom_range(MINT, MAXT-1)] = {$urandom, $urandom};
      case (f % 4)
        0:       thr = 64'd0;
        1:       thr = 64'($urandom_range(0, hi / 4 + 1));
        default: thr = 64'($urandom_range(0, hi));
      endcase
      run_frame($sformatf("rnd%0d", f), 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
